// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: arbiter state encoding, access-size codes and grant identifiers.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIAddr,
    StIData,
    StDAddr,
    StDData
  } arb_state_e;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  // Identifies which port owned the most recent grant.
  localparam logic GrantInst = 1'b0;
  localparam logic GrantData = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one SRAM-like bus, one transaction at a time.
// Contention is resolved round-robin; a flushed fetch completes downstream but is not reported.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  input  logic        cancel,
  output logic        stall_inst,
  output logic        stall_data
);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        drop_q, drop_d;
  logic        pay_wr_q, pay_wr_d;
  logic [1:0]  pay_size_q, pay_size_d;
  logic [31:0] pay_addr_q, pay_addr_d;
  logic [31:0] pay_wdata_q, pay_wdata_d;
  logic        grant_data;

  // Data wins when it is the only requester or when inst held the previous grant.
  assign grant_data = data_req & (~inst_req | (last_grant_q == GrantInst));

  // Next-state, grant bookkeeping, payload latch and fetch-drop flag.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    drop_d       = drop_q;
    pay_wr_d     = pay_wr_q;
    pay_size_d   = pay_size_q;
    pay_addr_d   = pay_addr_q;
    pay_wdata_d  = pay_wdata_q;
    case (state_q)
      StIdle: begin
        if (grant_data) begin
          state_d      = StDAddr;
          last_grant_d = GrantData;
          pay_wr_d     = data_wr;
          pay_size_d   = data_size;
          pay_addr_d   = data_addr;
          pay_wdata_d  = data_wdata;
        end else if (inst_req) begin
          state_d      = StIAddr;
          last_grant_d = GrantInst;
          pay_wr_d     = 1'b0;
          pay_size_d   = SizeWord;
          pay_addr_d   = inst_addr;
          pay_wdata_d  = 32'h0;
        end
      end
      StIAddr: begin
        if (cancel) drop_d = 1'b1;
        if (m_addr_ok) state_d = StIData;
      end
      StIData: begin
        // Completion always clears the drop flag, even if cancel arrives in the same cycle.
        if (m_data_ok) begin
          state_d = StIdle;
          drop_d  = 1'b0;
        end else if (cancel) begin
          drop_d = 1'b1;
        end
      end
      StDAddr: begin
        if (m_addr_ok) state_d = StDData;
      end
      StDData: begin
        if (m_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Downstream request, completion pulses and stall indications.
  always_comb begin
    m_req      = (state_q == StIAddr) | (state_q == StDAddr);
    m_wr       = pay_wr_q;
    m_size     = pay_size_q;
    m_addr     = pay_addr_q;
    m_wdata    = pay_wdata_q;
    inst_ok    = (state_q == StIData) & m_data_ok & ~drop_q & ~cancel;
    data_ok    = (state_q == StDData) & m_data_ok;
    inst_rdata = m_rdata;
    data_rdata = m_rdata;
    stall_inst = inst_req & ~inst_ok;
    stall_data = data_req & ~data_ok;
  end

  // State and payload registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      last_grant_q <= GrantInst;
      drop_q       <= 1'b0;
      pay_wr_q     <= 1'b0;
      pay_size_q   <= 2'd0;
      pay_addr_q   <= 32'h0;
      pay_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
      pay_wr_q     <= pay_wr_d;
      pay_size_q   <= pay_size_d;
      pay_addr_q   <= pay_addr_d;
      pay_wdata_q  <= pay_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle tables for the directed scenarios, hand sequences for
// round-robin and asynchronous reset, then random traffic against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        cancel, stall_inst, stall_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_ok    (inst_ok),
    .inst_rdata (inst_rdata),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_size  (data_size),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_ok    (data_ok),
    .data_rdata (data_rdata),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_size     (m_size),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_addr_ok  (m_addr_ok),
    .m_data_ok  (m_data_ok),
    .m_rdata    (m_rdata),
    .cancel     (cancel),
    .stall_inst (stall_inst),
    .stall_data (stall_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0; m_addr_ok = 0; m_data_ok = 0; m_rdata = 0; cancel = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic        pre_rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq, dwr;
    logic [1:0]  dsz;
    logic [31:0] daddr, dwdata;
    logic        aok, dok, cxl;
    logic [31:0] rdata;
    logic        e_mreq, e_mwr;
    logic [1:0]  e_msize;
    logic [31:0] e_maddr, e_mwdata;
    logic        e_iok, e_dok;
  } vec_t;

  vec_t        vq[$];
  logic        c_rst = 0;
  logic [31:0] c_iaddr = 0, c_daddr = 0, c_dwdata = 0;
  logic        c_dwr = 0;
  logic [1:0]  c_dsz = 0;

  task automatic ctx_i(input logic [31:0] a);
    c_iaddr = a;
  endtask

  task automatic ctx_d(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    c_dwr = wr; c_dsz = sz; c_daddr = a; c_dwdata = wd;
  endtask

  task automatic row(input logic ireq, input logic dreq, input logic aok, input logic dok,
                     input logic cxl, input logic [31:0] rdata, input logic e_mreq,
                     input logic e_mwr, input logic [1:0] e_msize, input logic [31:0] e_maddr,
                     input logic [31:0] e_mwdata, input logic e_iok, input logic e_dok);
    vec_t v;
    v.pre_rst = c_rst; c_rst = 0;
    v.ireq = ireq; v.iaddr = c_iaddr;
    v.dreq = dreq; v.dwr = c_dwr; v.dsz = c_dsz; v.daddr = c_daddr; v.dwdata = c_dwdata;
    v.aok = aok; v.dok = dok; v.cxl = cxl; v.rdata = rdata;
    v.e_mreq = e_mreq; v.e_mwr = e_mwr; v.e_msize = e_msize;
    v.e_maddr = e_maddr; v.e_mwdata = e_mwdata; v.e_iok = e_iok; v.e_dok = e_dok;
    vq.push_back(v);
  endtask

  task automatic build_table();
    // Fetch only, immediate handshakes.
    ctx_i(32'hBFC00000);
    row(1, 0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 32'h0,        1, 0, 2, 32'hBFC00000, 0, 0, 0);
    row(1, 0, 0, 1, 0, 32'h3C080001, 0, 0, 0, 32'h0, 0, 1, 0);
    row(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    // Contention straight after reset: store first, then fetch.
    c_rst = 1;
    ctx_i(32'hBFC00004);
    ctx_d(1, 2, 32'h80001000, 32'h12345678);
    row(1, 1, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    row(1, 1, 1, 1, 0, 32'h0,        1, 1, 2, 32'h80001000, 32'h12345678, 0, 0);
    row(1, 1, 1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 32'h0, 0, 0, 1);
    row(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 32'h0,        1, 0, 2, 32'hBFC00004, 0, 0, 0);
    row(1, 0, 0, 1, 0, 32'h11111111, 0, 0, 0, 32'h0, 0, 1, 0);
    row(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    // Cancel in I_DATA with delayed response, then refetch.
    ctx_i(32'hBFC00010);
    row(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 32'h0,        1, 0, 2, 32'hBFC00010, 0, 0, 0);
    row(1, 0, 0, 0, 1, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    ctx_i(32'hBFC00380);
    row(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    row(1, 0, 0, 1, 0, 32'h0BADF00D, 0, 0, 0, 32'h0, 0, 0, 0);
    row(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 32'h0,        1, 0, 2, 32'hBFC00380, 0, 0, 0);
    row(1, 0, 0, 1, 0, 32'h24020005, 0, 0, 0, 32'h0, 0, 1, 0);
    // Cancel coinciding with the response suppresses it.
    ctx_i(32'hBFC00384);
    row(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 32'h0,        1, 0, 2, 32'hBFC00384, 0, 0, 0);
    row(1, 0, 0, 1, 1, 32'h11112222, 0, 0, 0, 32'h0, 0, 0, 0);
    // Cancel while idle is ignored.
    ctx_i(32'hBFC00388);
    row(1, 0, 0, 0, 1, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 32'h0,        1, 0, 2, 32'hBFC00388, 0, 0, 0);
    row(1, 0, 0, 1, 0, 32'h33334444, 0, 0, 0, 32'h0, 0, 1, 0);
    row(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    // Load under address backpressure; stray m_data_ok and cancel ignored.
    ctx_d(0, 0, 32'h80002003, 32'h0);
    row(0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
    row(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 32'h80002003, 0, 0, 0);
    row(0, 1, 0, 1, 0, 32'h0,        1, 0, 0, 32'h80002003, 0, 0, 0);
    row(0, 1, 0, 0, 1, 32'h0,        1, 0, 0, 32'h80002003, 0, 0, 0);
    row(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 32'h80002003, 0, 0, 0);
    row(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 32'h80002003, 0, 0, 0);
    row(0, 1, 1, 0, 0, 32'h0,        1, 0, 0, 32'h80002003, 0, 0, 0);
    row(0, 1, 0, 1, 1, 32'h000000A5, 0, 0, 0, 32'h0, 0, 0, 1);
    row(0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic run_table();
    foreach (vq[k]) begin
      if (vq[k].pre_rst) do_reset();
      @(posedge clk);
      #1;
      inst_req = vq[k].ireq; inst_addr = vq[k].iaddr;
      data_req = vq[k].dreq; data_wr = vq[k].dwr; data_size = vq[k].dsz;
      data_addr = vq[k].daddr; data_wdata = vq[k].dwdata;
      m_addr_ok = vq[k].aok; m_data_ok = vq[k].dok; cancel = vq[k].cxl;
      m_rdata = vq[k].rdata;
      #4;
      chk($sformatf("row%0d m_req", k), m_req, vq[k].e_mreq);
      if (vq[k].e_mreq) begin
        chk($sformatf("row%0d m_wr", k), m_wr, vq[k].e_mwr);
        chk($sformatf("row%0d m_size", k), m_size, vq[k].e_msize);
        chk($sformatf("row%0d m_addr", k), m_addr, vq[k].e_maddr);
        if (vq[k].e_mwr) chk($sformatf("row%0d m_wdata", k), m_wdata, vq[k].e_mwdata);
      end
      chk($sformatf("row%0d inst_ok", k), inst_ok, vq[k].e_iok);
      chk($sformatf("row%0d data_ok", k), data_ok, vq[k].e_dok);
      chk($sformatf("row%0d stall_inst", k), stall_inst, vq[k].ireq & ~vq[k].e_iok);
      chk($sformatf("row%0d stall_data", k), stall_data, vq[k].dreq & ~vq[k].e_dok);
      if (vq[k].e_iok) chk($sformatf("row%0d inst_rdata", k), inst_rdata, vq[k].rdata);
      if (vq[k].e_dok) chk($sformatf("row%0d data_rdata", k), data_rdata, vq[k].rdata);
    end
  endtask

  // ---------------- hand sequences ----------------
  task automatic round_robin();
    logic [31:0] seen[$];
    logic [31:0] exp_order[4];
    do_reset();
    @(posedge clk);
    #1;
    inst_req = 1; inst_addr = 32'hBFC00100;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80003000;
    m_addr_ok = 1; m_data_ok = 1;
    for (int c = 0; c < 24; c++) begin
      #4;
      if (m_req) seen.push_back(m_addr);
      @(posedge clk);
      #1;
    end
    exp_order[0] = 32'h80003000; exp_order[1] = 32'hBFC00100;
    exp_order[2] = 32'h80003000; exp_order[3] = 32'hBFC00100;
    chk("rr_count_ge4", (seen.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      if (i < seen.size()) chk($sformatf("rr_grant%0d", i), seen[i], exp_order[i]);
    drive_idle();
  endtask

  task automatic reset_mid_transaction();
    // Reset during D_ADDR drops m_req at once.
    do_reset();
    @(posedge clk);
    #1 data_req = 1; data_addr = 32'h80004000; data_size = 2;
    @(posedge clk);
    #2 chk("rst_daddr_mreq_before", m_req, 1);
    resetn = 0;
    #1 chk("rst_daddr_mreq_after", m_req, 0);
    chk("rst_daddr_m_addr", m_addr, 32'h0);
    drive_idle();
    @(posedge clk);
    #1 resetn = 1;
    // Reset during D_DATA: a response arriving under reset must not complete anything.
    @(posedge clk);
    #1 data_req = 1; data_addr = 32'h80004004; data_size = 2;
    @(posedge clk);
    #1 m_addr_ok = 1;
    @(posedge clk);
    #1 m_addr_ok = 0;
    #1 chk("rst_ddata_mreq_before", m_req, 0);
    resetn = 0;
    m_data_ok = 1;
    #1 chk("rst_ddata_data_ok", data_ok, 0);
    chk("rst_ddata_mreq", m_req, 0);
    chk("rst_ddata_m_addr", m_addr, 32'h0);
    data_req = 0;
    @(posedge clk);
    #1 resetn = 1;
    for (int c = 0; c < 4; c++) begin
      #4;
      chk($sformatf("rst_after%0d data_ok", c), data_ok, 0);
      chk($sformatf("rst_after%0d m_req", c), m_req, 0);
      @(posedge clk);
      #1;
    end
    drive_idle();
  endtask

  // ---------------- random traffic vs transaction model ----------------
  task automatic random_traffic(input int ncyc);
    int          phase;      // 0 free, 1 address offered, 2 awaiting response
    bit          own_data, dropped, last_data;
    bit          clr_i, clr_d, flush_i, e_iok, e_dok;
    logic        x_wr;
    logic [1:0]  x_size;
    logic [31:0] x_addr, x_wdata;
    do_reset();
    phase = 0; last_data = 0; own_data = 0; dropped = 0;
    clr_i = 0; clr_d = 0; flush_i = 0;
    x_wr = 0; x_size = 0; x_addr = 0; x_wdata = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(posedge clk);
      #1;
      if (clr_i) inst_req = 0;
      if (clr_d) data_req = 0;
      if (flush_i) inst_addr = $urandom & 32'hFFFF_FFFC;
      clr_i = 0; clr_d = 0; flush_i = 0;
      if (!inst_req && $urandom_range(3) == 0) begin
        inst_req = 1; inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req && $urandom_range(3) == 0) begin
        data_req = 1; data_wr = 1'($urandom_range(1)); data_size = 2'($urandom_range(2));
        data_addr = $urandom; data_wdata = $urandom;
      end
      m_addr_ok = 1'($urandom_range(1));
      m_data_ok = (phase == 2) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      m_rdata = $urandom;
      cancel = ($urandom_range(5) == 0);
      #4;
      e_iok = (phase == 2) && !own_data && m_data_ok && !dropped && !cancel;
      e_dok = (phase == 2) && own_data && m_data_ok;
      chk($sformatf("rnd%0d m_req", cyc), m_req, (phase == 1));
      if (phase == 1) begin
        chk($sformatf("rnd%0d m_wr", cyc), m_wr, x_wr);
        chk($sformatf("rnd%0d m_size", cyc), m_size, x_size);
        chk($sformatf("rnd%0d m_addr", cyc), m_addr, x_addr);
        if (x_wr) chk($sformatf("rnd%0d m_wdata", cyc), m_wdata, x_wdata);
      end
      chk($sformatf("rnd%0d inst_ok", cyc), inst_ok, e_iok);
      chk($sformatf("rnd%0d data_ok", cyc), data_ok, e_dok);
      chk($sformatf("rnd%0d stall_inst", cyc), stall_inst, inst_req & ~e_iok);
      chk($sformatf("rnd%0d stall_data", cyc), stall_data, data_req & ~e_dok);
      if (e_iok) chk($sformatf("rnd%0d inst_rdata", cyc), inst_rdata, m_rdata);
      if (e_dok) chk($sformatf("rnd%0d data_rdata", cyc), data_rdata, m_rdata);
      // Requester reactions, applied at the start of the next cycle.
      clr_i = e_iok;
      clr_d = e_dok;
      if (phase != 0 && !own_data && cancel) flush_i = 1;
      if (phase != 0 && !own_data && !e_iok && $urandom_range(15) == 0) clr_i = 1;
      if (phase != 0 && own_data && !e_dok && $urandom_range(15) == 0) clr_d = 1;
      // Advance the transaction model.
      case (phase)
        0: if (inst_req || data_req) begin
          own_data = data_req && (!inst_req || !last_data);
          last_data = own_data;
          dropped = 0;
          phase = 1;
          if (own_data) begin
            x_wr = data_wr; x_size = data_size; x_addr = data_addr; x_wdata = data_wdata;
          end else begin
            x_wr = 0; x_size = 2; x_addr = inst_addr; x_wdata = 0;
          end
        end
        1: begin
          if (!own_data && cancel) dropped = 1;
          if (m_addr_ok) phase = 2;
        end
        default: begin
          if (m_data_ok) phase = 0;
          else if (!own_data && cancel) dropped = 1;
        end
      endcase
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    resetn = 0;
    m_data_ok = 1;
    m_addr_ok = 1;
    #3;
    chk("reset m_req", m_req, 0);
    chk("reset inst_ok", inst_ok, 0);
    chk("reset data_ok", data_ok, 0);
    chk("reset m_addr", m_addr, 32'h0);
    chk("reset m_wr", m_wr, 0);
    chk("reset m_size", m_size, 0);
    chk("reset m_wdata", m_wdata, 32'h0);
    drive_idle();
    repeat (2) @(posedge clk);
    #1 resetn = 1;

    build_table();
    run_table();
    round_robin();
    reset_mid_transaction();
    random_traffic(4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port list (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request; held with stable inst_addr until inst_ok
- inst_addr  in  32  fetch address
- inst_ok  out  1  one-cycle pulse: fetch complete, inst_rdata valid
- inst_rdata  out  32  fetched word
- data_req  in  1  load/store request; held with stable payload until data_ok
- data_wr  in  1  1=store, 0=load
- data_size  in  2  0=byte, 1=half, 2=word
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_ok  out  1  one-cycle pulse: data access complete
- data_rdata  out  32  load data, valid with data_ok
- m_req  out  1  downstream SRAM-like request
- m_wr, m_size, m_addr, m_wdata  out  1/2/32/32  downstream payload
- m_addr_ok  in  1  downstream accepted address
- m_data_ok  in  1  downstream response/completion
- m_rdata  in  32  downstream read data
- cancel  in  1  pipeline flush; drop in-flight fetch response
- stall_inst  out  1  inst_req & ~inst_ok
- stall_data  out  1  data_req & ~data_ok

Function
REQ-003 The FSM SHALL have states IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA; one downstream transaction outstanding at most.
REQ-004 In IDLE, a single pending requester SHALL be granted; the next state is its *_ADDR state.
REQ-005 When both are pending in IDLE, the grant SHALL go to the port not granted last (last_grant register); after reset, data wins.
REQ-006 At grant, the payload SHALL be latched; m_* SHALL be driven from the latch (inst: m_wr=0, m_size=2).
REQ-007 m_req SHALL be 1 exactly in *_ADDR states; m_addr_ok there moves to the matching *_DATA state.
REQ-008 In *_DATA, m_data_ok SHALL return to IDLE and combinationally pulse the port's *_ok for that cycle.
REQ-009 inst_rdata and data_rdata SHALL pass m_rdata through.
REQ-010 Minimum latency: request seen at cycle 0, m_req at cycle 1, *_ok at cycle 2 when m_addr_ok and m_data_ok each arrive in their first cycle.
REQ-011 cancel in I_ADDR or I_DATA SHALL set a drop flag; the transaction completes downstream, but inst_ok stays 0 and the flag clears on m_data_ok.
REQ-012 cancel in IDLE or any D_* state SHALL have no effect; cancel never alters data transactions.
REQ-013 cancel coinciding with m_data_ok in I_DATA SHALL suppress that inst_ok.
REQ-014 A new inst_req presented while the drop flag is set SHALL wait for IDLE; stall_inst stays 1.
REQ-015 m_addr_ok outside *_ADDR and m_data_ok outside *_DATA SHALL be ignored.
REQ-016 A requester dropping req before its *_ok SHALL NOT abort the granted transaction.

Reset
REQ-017 On resetn low, the block SHALL immediately force: state=IDLE, m_req=0, drop flag=0, last_grant=inst, latched payload=0, inst_ok=data_ok=0.
REQ-018 Reset mid-transaction SHALL abandon it silently; downstream is reset by the same resetn.

Structure
REQ-019 State encoding and the size constants (BYTE/HALF/WORD) SHALL live in the shared CPU package.
REQ-020 The block SHALL be a single module with no sub-modules.

Verification
REQ-021 Fetch only: inst_addr=0xBFC00000, addr_ok and data_ok immediate, m_rdata=0x3C080001 -> m_req at cycle 1, inst_ok with 0x3C080001 at cycle 2.
REQ-022 Contention after reset: inst and data (store, size 2, addr 0x80001000, wdata 0x12345678) at the same cycle -> data granted first (m_wr=1), then inst; stall_inst=1 throughout the store.
REQ-023 Round-robin: both requesters held continuously for 4 transactions -> grant order D, I, D, I.
REQ-024 Cancel: fetch 0xBFC00010 with m_data_ok delayed 3 cycles, cancel pulsed in I_DATA -> no inst_ok; next fetch 0xBFC00380 is granted and its inst_ok is seen.
REQ-025 Backpressure: m_addr_ok held low 5 cycles on a load -> m_req and m_addr stable for all 5 cycles, single data_ok.
REQ-026 resetn low during D_DATA -> m_req=0 and state IDLE immediately; no data_ok after release.
